gru_hidden_update_scheduler: RTL and testbench

//  Sequences one shared h_t element unit across all HIDDEN_SIZE elements of a GRU step.
//  For each element index i it does four things:
//   - reads z[i], n[i] and h_prev[i] from gate/state buffers (1-cycle read latency);
//   - issues them to the element unit with a one-cycle valid pulse;
//   - waits for the unit's valid pulse;
//   - writes h_t[i] to the new-hidden-state buffer.

---
 rtl/gru_hidden_update_scheduler.sv | 139 +++++++++++++
 tb/tb_gru_hidden_update_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gru_hidden_update_scheduler.sv
// Walks one shared GRU h_t element unit over all hidden elements of a step:
// fetch z/n/h_prev, issue, wait for the result, write h_t, then the next index.
module gru_hidden_update_scheduler #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FRAC_BITS      = 8,
  parameter int unsigned HIDDEN_SIZE    = 8,
  parameter int unsigned IDX_W          = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [IDX_W-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0] z_rd_data,
  input  logic [DATA_WIDTH-1:0] n_rd_data,
  input  logic [DATA_WIDTH-1:0] hprev_rd_data,
  output logic                  elem_valid_in,
  output logic [DATA_WIDTH-1:0] elem_z,
  output logic [DATA_WIDTH-1:0] elem_n,
  output logic [DATA_WIDTH-1:0] elem_h_prev,
  input  logic                  elem_valid_out,
  input  logic [DATA_WIDTH-1:0] elem_h,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIDDEN_SIZE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  // Data format is carried bit-exact; fractional bits must fit inside the word.
  if (FRAC_BITS > DATA_WIDTH || HIDDEN_SIZE < 1 || TIMEOUT_CYCLES < 3) begin : g_bad_params
    $error("gru_hidden_update_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TO_W-1:0]  wait_cnt;

  // Read data arrives the cycle after rd_en, which is exactly the ISSUE cycle.
  assign elem_z      = z_rd_data;
  assign elem_n      = n_rd_data;
  assign elem_h_prev = hprev_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      elem_valid_in <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      rd_en         <= 1'b0;
      elem_valid_in <= 1'b0;
      wr_en         <= 1'b0;
      done          <= 1'b0;
      if (state != S_IDLE && abort) begin
        state <= S_IDLE;
        idx   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state   <= S_FETCH;
              idx     <= '0;
              err     <= 1'b0;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
          S_FETCH: begin
            state         <= S_ISSUE;
            elem_valid_in <= 1'b1;
          end
          S_ISSUE: begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
          S_WAIT: begin
            if (elem_valid_out) begin
              state   <= S_WRITE;
              wr_en   <= 1'b1;
              wr_addr <= idx;
              wr_data <= elem_h;
            end else if (wait_cnt == TO_LAST) begin
              state <= S_IDLE;
              idx   <= '0;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + TO_W'(1);
            end
          end
          S_WRITE: begin
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_FETCH;
              idx     <= idx + IDX_W'(1);
              rd_en   <= 1'b1;
              rd_addr <= idx + IDX_W'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gru_hidden_update_scheduler.sv
// Directed bench for gru_hidden_update_scheduler with buffer and element-unit models.
module tb_gru_hidden_update_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err, rd_en, elem_valid_in, wr_en, elem_valid_out;
  logic [2:0]  rd_addr, wr_addr;
  logic [15:0] z_rd_data, n_rd_data, hprev_rd_data;
  logic [15:0] elem_z, elem_n, elem_h_prev, elem_h, wr_data;

  always #5 clk = ~clk;

  gru_hidden_update_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .z_rd_data(z_rd_data), .n_rd_data(n_rd_data), .hprev_rd_data(hprev_rd_data),
    .elem_valid_in(elem_valid_in), .elem_z(elem_z), .elem_n(elem_n),
    .elem_h_prev(elem_h_prev), .elem_valid_out(elem_valid_out), .elem_h(elem_h),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int checks = 0;
  int errors = 0;

  // Gate/state buffers with 1-cycle read latency
  logic [15:0] z_mem [8];
  logic [15:0] n_mem [8];
  logic [15:0] h_mem [8];
  always @(posedge clk) begin
    if (rd_en) begin
      z_rd_data     <= z_mem[rd_addr];
      n_rd_data     <= n_mem[rd_addr];
      hprev_rd_data <= h_mem[rd_addr];
    end
  end

  // Element unit model: answers 2 cycles after the issue cycle
  bit          gru_mode = 1'b0;
  bit          mute_en = 1'b0;
  logic [2:0]  mute_addr = 3'd0;
  bit          spur = 1'b0;
  logic        mdl_p1, mdl_vo;
  logic [15:0] mdl_h1, mdl_h;
  logic [2:0]  mdl_addr;

  function automatic logic [15:0] calc(input logic [15:0] z, input logic [15:0] n,
                                       input logic [15:0] hp);
    logic signed [31:0] p;
    if (gru_mode) begin
      p = 32'($signed(z)) * (32'($signed(hp)) - 32'($signed(n)));
      return n + 16'(p >>> 8);
    end
    return z + n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_p1 <= 1'b0; mdl_vo <= 1'b0; mdl_h1 <= '0; mdl_h <= '0; mdl_addr <= '0;
    end else begin
      if (rd_en) mdl_addr <= rd_addr;
      mdl_p1 <= elem_valid_in && !(mute_en && mdl_addr == mute_addr);
      mdl_h1 <= calc(elem_z, elem_n, elem_h_prev);
      mdl_vo <= mdl_p1;
      mdl_h  <= mdl_h1;
    end
  end
  assign elem_valid_out = mdl_vo | spur;
  assign elem_h         = spur ? 16'hDEAD : mdl_h;

  // Write log
  int          wr_cnt = 0;
  logic [2:0]  wr_addr_log [16];
  logic [15:0] wr_data_log [16];
  always @(negedge clk) begin
    if (wr_en && wr_cnt < 16) begin
      wr_addr_log[wr_cnt] = wr_addr;
      wr_data_log[wr_cnt] = wr_data;
      wr_cnt++;
    end
  end

  int busy_first, busy_last, busy_cnt, done_cnt, done_cyc;
  logic err_c1, vi_at_rst;

  // Start a step at cycle 0 and observe cycles 1.. until busy drops (or reset injection)
  task automatic run_step(input int abort_cyc, input bit spam, input bit spur_on,
                          input int rst_cyc);
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    busy_first = -1; busy_last = -1; err_c1 = 1'bx; vi_at_rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) err_c1 = err;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (done) begin done_cnt++; done_cyc = k; end
      if (!busy) begin start = 1'b0; abort = 1'b0; spur = 1'b0; break; end
      if (k == 200) begin
        checks++; errors++;
        $display("FAIL step_bound: busy still %b after %0d cycles, required 0", busy, k);
      end
      start = spam;
      abort = (k == abort_cyc);
      spur  = spur_on && rd_en;
      if (k == rst_cyc) begin
        vi_at_rst = elem_valid_in;
        start = 1'b0; abort = 1'b0; spur = 1'b0;
        rst = 1'b1;
        #1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if ({rd_en, elem_valid_in, wr_en} !== 3'b000) begin
      errors++; $display("FAIL rst_strobes: got %b want 000", {rd_en, elem_valid_in, wr_en});
    end
    checks++; if ({rd_addr, wr_addr, wr_data} !== 22'd0) begin
      errors++; $display("FAIL rst_addr_data: got %h want 0", {rd_addr, wr_addr, wr_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_full_step();
    gru_mode = 1'b0;
    run_step(0, 1'b0, 1'b0, 0);
    checks++; if (done_cnt !== 1 || done_cyc !== 41) begin
      errors++; $display("FAIL full_done: got cnt %0d cyc %0d want 1 at 41", done_cnt, done_cyc);
    end
    checks++; if (busy_first !== 1 || busy_last !== 41 || busy_cnt !== 41) begin
      errors++; $display("FAIL full_busy: got %0d..%0d (%0d) want 1..41", busy_first, busy_last, busy_cnt);
    end
    checks++; if (wr_cnt !== 8) begin errors++; $display("FAIL full_wr_cnt: got %0d want 8", wr_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr_log[i] !== 3'(i) || wr_data_log[i] !== 16'(z_mem[i] + n_mem[i])) begin
        errors++;
        $display("FAIL full_wr%0d: got addr %0d data %h want addr %0d data %h", i,
                 wr_addr_log[i], wr_data_log[i], i, 16'(z_mem[i] + n_mem[i]));
      end
    end
  endtask

  task automatic test_gru_value();
    gru_mode = 1'b1;
    z_mem[3] = 16'h0080; n_mem[3] = 16'h0100; h_mem[3] = 16'h0200;
    run_step(0, 1'b0, 1'b0, 0);
    checks++; if (wr_addr_log[3] !== 3'd3 || wr_data_log[3] !== 16'h0180) begin
      errors++; $display("FAIL gru_value: got addr %0d data %h want addr 3 data 0180",
                         wr_addr_log[3], wr_data_log[3]);
    end
    gru_mode = 1'b0;
  endtask

  task automatic test_timeout();
    mute_en = 1'b1; mute_addr = 3'd2;
    run_step(0, 1'b0, 1'b0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
    checks++; if (busy_last !== 20) begin errors++; $display("FAIL to_busy_last: got %0d want 20", busy_last); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL to_done: got %0d want 0", done_cnt); end
    checks++; if (wr_cnt !== 2 || wr_addr_log[0] !== 3'd0 || wr_addr_log[1] !== 3'd1) begin
      errors++; $display("FAIL to_writes: got cnt %0d want 2 (addr 0,1)", wr_cnt);
    end
    mute_en = 1'b0;
    run_step(0, 1'b0, 1'b0, 0);
    checks++; if (err_c1 !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", err_c1); end
    checks++; if (done_cyc !== 41 || wr_cnt !== 8) begin
      errors++; $display("FAIL to_rerun: got done %0d writes %0d want 41 and 8", done_cyc, wr_cnt);
    end
  endtask

  task automatic test_abort();
    run_step(23, 1'b0, 1'b0, 0);
    checks++; if (busy_last !== 23) begin errors++; $display("FAIL ab_busy_last: got %0d want 23", busy_last); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL ab_done: got %0d want 0", done_cnt); end
    checks++; if (wr_cnt !== 4) begin errors++; $display("FAIL ab_writes: got %0d want 4", wr_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ab_err: got %b want 0", err); end
    run_step(0, 1'b0, 1'b0, 0);
    checks++; if (wr_addr_log[0] !== 3'd0 || wr_cnt !== 8 || done_cyc !== 41) begin
      errors++; $display("FAIL ab_restart: got first addr %0d writes %0d done %0d want 0 8 41",
                         wr_addr_log[0], wr_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    run_step(0, 1'b1, 1'b1, 0);
    repeat (5) @(negedge clk);
    checks++; if (done_cnt !== 1 || done_cyc !== 41) begin
      errors++; $display("FAIL b2b_done: got cnt %0d cyc %0d want 1 at 41", done_cnt, done_cyc);
    end
    checks++; if (wr_cnt !== 8 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_single: got writes %0d busy %b want 8 and 0", wr_cnt, busy);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr_log[i] !== 3'(i) || wr_data_log[i] !== 16'(z_mem[i] + n_mem[i])) begin
        errors++; $display("FAIL b2b_wr%0d: got addr %0d data %h want addr %0d data %h", i,
                           wr_addr_log[i], wr_data_log[i], i, 16'(z_mem[i] + n_mem[i]));
      end
    end
  endtask

  task automatic test_reset_mid_step();
    run_step(0, 1'b0, 1'b0, 27);
    checks++; if (vi_at_rst !== 1'b1) begin errors++; $display("FAIL mid_issue: got %b want 1", vi_at_rst); end
    checks++; if ({busy, done, err, rd_en, elem_valid_in, wr_en} !== 6'd0) begin
      errors++; $display("FAIL mid_ctrl: got %b want 000000", {busy, done, err, rd_en, elem_valid_in, wr_en});
    end
    checks++; if ({rd_addr, wr_addr, wr_data} !== 22'd0) begin
      errors++; $display("FAIL mid_addr_data: got %h want 0", {rd_addr, wr_addr, wr_data});
    end
    checks++; if (wr_cnt !== 5) begin errors++; $display("FAIL mid_writes: got %0d want 5", wr_cnt); end
    @(negedge clk);
    rst = 1'b0;
    run_step(0, 1'b0, 1'b0, 0);
    checks++; if (done_cyc !== 41 || busy_cnt !== 41 || wr_cnt !== 8) begin
      errors++; $display("FAIL mid_rerun: got done %0d busy %0d writes %0d want 41 41 8",
                         done_cyc, busy_cnt, wr_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      z_mem[i] = 16'h0011 * 16'(i + 1);
      n_mem[i] = 16'h0100 + 16'h0203 * 16'(i);
      h_mem[i] = 16'h0400 - 16'h0010 * 16'(i);
    end
    test_reset();
    test_full_step();
    test_gru_value();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
